bus_arbiter4: RTL and testbench

//  Round-robin arbiter sharing the 8-bit internal bus among four requesters.

---
 rtl/bus_arb_pkg.sv | 14 +
 rtl/rr_pick4.sv | 36 +++
 rtl/bus_arbiter4.sv | 109 ++++++++++
 tb/tb_bus_arbiter4.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and sizes for the four-way round-robin bus arbiter.
// State encoding is fixed so the state register can be decoded directly.
package bus_arb_pkg;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    PARK = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: rotate requests so (last+1) sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick4
  import bus_arb_pkg::*;
(
  input  logic [N_REQ-1:0]  req,
  input  logic [ADDR_W-1:0] last,
  output logic              valid,
  output logic [ADDR_W-1:0] idx
);

  logic [ADDR_W-1:0] start;
  logic [N_REQ-1:0]  rot;
  logic [ADDR_W-1:0] enc;

  assign start = last + 2'd1;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [ADDR_W-1:0] src;
      assign src     = start + ADDR_W'(gi);
      assign rot[gi] = req[src];
    end
  endgenerate

  always_comb begin
    enc = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = ADDR_W'(i);
    end
  end

  assign valid = |rot;
  assign idx   = start + enc;

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin owner of the 8-bit internal bus, granting whole machine cycles
// framed by the beat generator's T pulses, with a one-clock turnaround.
module bus_arbiter4
  import bus_arb_pkg::*;
#(
  parameter int MAX_CYC  = 4,
  parameter int ARB_BEAT = 0,
  parameter int END_BEAT = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          T,
  input  logic [N_REQ-1:0]    req,
  output logic [N_REQ-1:0]    gnt,
  output logic [ADDR_W-1:0]   addr,
  output logic                busy,
  output logic                preempt
);

  localparam logic [7:0] ARB_MASK = 8'd1 << ARB_BEAT;
  localparam logic [7:0] END_MASK = 8'd1 << END_BEAT;
  localparam logic [3:0] CNT_LAST = 4'(MAX_CYC - 1);

  arb_state_e          state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                preempt_q, preempt_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   last_q, last_d;

  logic                arb_hit, end_hit;
  logic                pick_valid;
  logic [ADDR_W-1:0]   pick_idx;

  // Masking the whole vector keeps the unexamined beat bits harmless.
  assign arb_hit = |(T & ARB_MASK);
  assign end_hit = |(T & END_MASK);

  rr_pick4 u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        // An illegal T with both beats set never arbitrates.
        if (arb_hit && !end_hit && pick_valid) begin
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          addr_d  = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
          state_d = OWN;
        end
      end
      OWN: begin
        if (end_hit) begin
          if (!req[addr_q] || cnt_q == CNT_LAST) begin
            gnt_d     = '0;
            busy_d    = 1'b0;
            last_d    = addr_q;
            preempt_d = req[addr_q];
            state_d   = PARK;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      PARK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      cnt_q     <= 4'd0;
      last_q    <= 2'd3;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  assign gnt     = gnt_q;
  assign addr    = addr_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4: each beat is one T pulse clock preceded
// by one quiet clock, so a PARK turnaround never swallows the next T[0].
module tb_bus_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [7:0] T;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] addr;
  logic       busy;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter4 #(.MAX_CYC(4), .ARB_BEAT(0), .END_BEAT(7)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .T       (T),
    .req     (req),
    .gnt     (gnt),
    .addr    (addr),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic beat(input int k);
    @(posedge clk); #1;
    T = 8'd1 << k;
    @(posedge clk); #1;
    T = 8'h00;
  endtask

  task automatic beats(input int from, input int to);
    for (int k = from; k <= to; k++) beat(k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; T = 8'h00; req = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; T = 8'h01; req = 4'hF;
    @(posedge clk); #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_checks++; if (addr !== 2'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", addr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (preempt !== 1'b0) begin n_fail++; $display("FAIL reset_preempt: got %b want 0", preempt); end
    T = 8'h00; req = 4'h0;
    @(posedge clk); #1 rst_n = 1'b1;
    $display("test_reset: gnt=%b addr=%0d busy=%b", gnt, addr, busy);
  endtask

  task automatic test_basic_grant();
    do_reset();
    req = 4'b1111;
    beat(0);
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL basic_first_gnt: got %b want 0001", gnt); end
    n_checks++; if (addr !== 2'd0) begin n_fail++; $display("FAIL basic_first_addr: got %0d want 0", addr); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_first_busy: got %b want 1", busy); end
    beats(1, 6);
    req = 4'b1110;
    beat(7);
    n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_release: got gnt=%b busy=%b want 0000/0", gnt, busy); end
    n_checks++; if (preempt !== 1'b0) begin n_fail++; $display("FAIL basic_no_preempt: got %b want 0", preempt); end
    beat(0);
    n_checks++; if (gnt !== 4'b0010 || addr !== 2'd1) begin n_fail++; $display("FAIL basic_second: got gnt=%b addr=%0d want 0010/1", gnt, addr); end
    req = 4'b0000;
    beats(1, 7);
    $display("test_basic_grant: second owner addr=%0d", addr);
  endtask

  task automatic test_preempt();
    do_reset();
    req = 4'b1000;
    beat(0);
    n_checks++; if (gnt !== 4'b1000 || addr !== 2'd3) begin n_fail++; $display("FAIL preempt_grant: got gnt=%b addr=%0d want 1000/3", gnt, addr); end
    for (int c = 0; c < 4; c++) begin
      if (c > 0) beat(0);
      beats(1, 7);
      if (c < 3) begin
        n_checks++; if (gnt !== 4'b1000 || preempt !== 1'b0) begin n_fail++; $display("FAIL preempt_hold%0d: got gnt=%b preempt=%b want 1000/0", c, gnt, preempt); end
      end
    end
    n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL preempt_release: got gnt=%b busy=%b want 0000/0", gnt, busy); end
    n_checks++; if (preempt !== 1'b1) begin n_fail++; $display("FAIL preempt_pulse: got %b want 1", preempt); end
    n_checks++; if (addr !== 2'd3) begin n_fail++; $display("FAIL preempt_addr: got %0d want 3", addr); end
    beat(0);
    n_checks++; if (preempt !== 1'b0) begin n_fail++; $display("FAIL preempt_one_clock: got %b want 0", preempt); end
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL preempt_regrant: got %b want 1000", gnt); end
    req = 4'b0000;
    beats(1, 7);
    $display("test_preempt: regrant gnt after release=%b", gnt);
  endtask

  task automatic test_round_robin();
    int exp_order[4] = '{2, 0, 2, 0};
    do_reset();
    req = 4'b0001;
    beat(0);
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rr_setup: got %b want 0001", gnt); end
    beats(1, 6);
    req = 4'b0000;
    beat(7);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_gnt;
      exp_gnt = 4'd1 << exp_order[i];
      req = 4'b0101;
      beat(0);
      n_checks++; if (gnt !== exp_gnt || addr !== 2'(exp_order[i])) begin n_fail++; $display("FAIL rr_order%0d: got gnt=%b addr=%0d want %b/%0d", i, gnt, addr, exp_gnt, exp_order[i]); end
      beats(1, 6);
      req = 4'b0101 & ~exp_gnt;
      beat(7);
      $display("test_round_robin: grant %0d -> addr=%0d", i, addr);
    end
    req = 4'b0000;
  endtask

  task automatic test_midcycle_drop();
    do_reset();
    req = 4'b0010;
    beat(0);
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL drop_grant: got %b want 0010", gnt); end
    beats(1, 2);
    req = 4'b0000;
    beat(3);
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL drop_midcycle: got %b want 0010", gnt); end
    req = 4'b0010;
    beats(4, 7);
    n_checks++; if (gnt !== 4'b0010 || busy !== 1'b1) begin n_fail++; $display("FAIL drop_kept: got gnt=%b busy=%b want 0010/1", gnt, busy); end
    req = 4'b0000;
    beats(0, 7);
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL drop_final_release: got %b want 0000", gnt); end
    $display("test_midcycle_drop: gnt=%b", gnt);
  endtask

  task automatic test_reset_midgrant();
    do_reset();
    req = 4'b0100;
    beat(0);
    n_checks++; if (gnt !== 4'b0100 || addr !== 2'd2) begin n_fail++; $display("FAIL rstmid_grant: got gnt=%b addr=%0d want 0100/2", gnt, addr); end
    beat(1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || addr !== 2'd0) begin n_fail++; $display("FAIL rstmid_drop: got gnt=%b busy=%b addr=%0d want 0000/0/0", gnt, busy, addr); end
    rst_n = 1'b1;
    req = 4'b0101;
    beat(0);
    n_checks++; if (gnt !== 4'b0001 || addr !== 2'd0) begin n_fail++; $display("FAIL rstmid_req0_first: got gnt=%b addr=%0d want 0001/0", gnt, addr); end
    req = 4'b0000;
    beats(1, 7);
    $display("test_reset_midgrant: gnt=%b", gnt);
  endtask

  task automatic test_idle_and_illegal();
    do_reset();
    req = 4'b0010;
    beat(0);
    beats(1, 6);
    req = 4'b0000;
    beat(7);
    for (int c = 0; c < 3; c++) begin
      beats(0, 7);
      n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || addr !== 2'd1) begin n_fail++; $display("FAIL idle_steady%0d: got gnt=%b busy=%b addr=%0d want 0000/0/1", c, gnt, busy, addr); end
    end
    req = 4'b0011;
    beat(0);
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL illegal_setup: got %b want 0001", gnt); end
    beats(1, 6);
    req = 4'b0010;
    @(posedge clk); #1;
    T = 8'h81;
    @(posedge clk); #1;
    T = 8'h00;
    n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL illegal_release_only: got gnt=%b busy=%b want 0000/0", gnt, busy); end
    n_checks++; if (addr !== 2'd0) begin n_fail++; $display("FAIL illegal_addr: got %0d want 0", addr); end
    beat(0);
    n_checks++; if (gnt !== 4'b0010 || addr !== 2'd1) begin n_fail++; $display("FAIL illegal_next_grant: got gnt=%b addr=%0d want 0010/1", gnt, addr); end
    req = 4'b0000;
    beats(1, 7);
    $display("test_idle_and_illegal: gnt=%b addr=%0d", gnt, addr);
  endtask

  initial begin
    rst_n = 1'b0; T = 8'h00; req = 4'h0;
    @(posedge clk); #1;
    test_reset();
    test_basic_grant();
    test_preempt();
    test_round_robin();
    test_midcycle_drop();
    test_reset_midgrant();
    test_idle_and_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
